vram_arbiter: RTL

//  Shares the single-port 64K x 16-bit VRAM among four requesters: video fetch, register-interface

---
 rtl/vram_arbiter.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares a single-port 64K x 16 VRAM between four requesters:
//   video fetch (read), register read, register write, and blitter (read/write).
// Video wins over the other three unless one of them has waited STARVE_MAX
// cycles. Register read, register write and blitter share a round-robin
// pointer. The VRAM port is fully registered, and read data comes back with a
// fixed 2-cycle latency, tagged back to the requester that issued the read.
//
// Handshake (every requester): a transfer happens on the rising edge where
// req && ack. The requester holds req/addr/data stable until it sees ack, and
// may keep req high for back-to-back transfers, updating addr on the ack edge.
// An ack is combinational from the current reqs and registered state. At most
// one ack is high in any cycle.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   vid_req_i/vid_addr_i              video read request
//   vid_ack_o, vid_rd_valid_o         video accept / read data valid
//   regs_rd_req_i/regs_rd_addr_i      register read request
//   regs_rd_ack_o, regs_rd_valid_o    register read accept / data valid
//   regs_wr_req_i/_addr_i/_data_i     register write request
//   regs_wr_ack_o                     register write accept
//   blit_req_i/_we_i/_addr_i/_data_i  blitter request (we=1 write, 0 read)
//   blit_ack_o, blit_rd_valid_o       blitter accept / read data valid
//   rd_data_o                         shared read data (qualify with *_rd_valid_o)
//   vram_sel_o/_wr_o/_addr_o/_data_o  registered VRAM port
//   vram_data_i                       VRAM read data, 1 cycle after sel sampled
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req_i,
    input  logic [ADDR_W-1:0] vid_addr_i,
    output logic              vid_ack_o,
    output logic              vid_rd_valid_o,
    input  logic              regs_rd_req_i,
    input  logic [ADDR_W-1:0] regs_rd_addr_i,
    output logic              regs_rd_ack_o,
    output logic              regs_rd_valid_o,
    input  logic              regs_wr_req_i,
    input  logic [ADDR_W-1:0] regs_wr_addr_i,
    input  logic [DATA_W-1:0] regs_wr_data_i,
    output logic              regs_wr_ack_o,
    input  logic              blit_req_i,
    input  logic              blit_we_i,
    input  logic [ADDR_W-1:0] blit_addr_i,
    input  logic [DATA_W-1:0] blit_data_i,
    output logic              blit_ack_o,
    output logic              blit_rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic [DATA_W-1:0] vram_data_i
);

    // A zero-width counter is not legal, so STARVE_MAX=0 keeps a 1-bit counter
    // that never leaves zero and never preempts.
    localparam int              CNT_W      = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(STARVE_MAX);
    localparam bit              PREEMPT_EN = (STARVE_MAX != 0);

    // Round-robin pointer: which of rd/wr/blit currently has top priority.
    typedef enum logic [1:0] {
        RR_RD   = 2'd0,
        RR_WR   = 2'd1,
        RR_BLIT = 2'd2
    } rr_t;

    // Bit order for the three round-robin requesters: [0]=rd [1]=wr [2]=blit.
    // Bit order for read owner tags:                  [0]=vid [1]=rd [2]=blit.

    rr_t               r_rr_ptr;
    rr_t               w_rr_ptr_nxt;
    logic [CNT_W-1:0]  r_wait [3];
    logic [2:0]        w_rr_req;
    logic [2:0]        w_starved;
    logic [2:0]        w_rr_mask;
    logic [2:0]        w_rr_gnt;
    logic              w_vid_gnt;
    logic              w_xfer;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [2:0]        w_rd_tag;

    logic              r_vram_sel;
    logic              r_vram_wr;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [DATA_W-1:0] r_vram_data;
    logic [2:0]        r_tag1;
    logic [2:0]        r_tag2;
    logic [2:0]        r_valid;
    logic [DATA_W-1:0] r_rd_data;

    // Pick the first set bit of mask, scanning rd->wr->blit starting at ptr.
    function automatic logic [2:0] rr_pick(input logic [2:0] mask, input rr_t ptr);
        logic [2:0] rot;
        logic [2:0] g;
        logic [2:0] res;
        case (ptr)
            RR_WR:   rot = {mask[0], mask[2:1]};
            RR_BLIT: rot = {mask[1:0], mask[2]};
            default: rot = mask;
        endcase
        if (rot[0])      g = 3'b001;
        else if (rot[1]) g = 3'b010;
        else if (rot[2]) g = 3'b100;
        else             g = 3'b000;
        case (ptr)
            RR_WR:   res = {g[1], g[0], g[2]};
            RR_BLIT: res = {g[0], g[2], g[1]};
            default: res = g;
        endcase
        return res;
    endfunction

    assign w_rr_req = {blit_req_i, regs_wr_req_i, regs_rd_req_i};

    always_comb begin
        w_starved = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_starved[i] = PREEMPT_EN && w_rr_req[i] && (r_wait[i] == WAIT_MAX);
        end
    end

    // Starved requesters override video; otherwise video blocks the RR group.
    always_comb begin
        w_rr_mask = 3'b000;
        w_vid_gnt = 1'b0;
        if (|w_starved) begin
            w_rr_mask = w_starved;
        end else if (vid_req_i) begin
            w_vid_gnt = 1'b1;
        end else begin
            w_rr_mask = w_rr_req;
        end
        w_rr_gnt = rr_pick(w_rr_mask, r_rr_ptr);
    end

    // Internal grants are not gated by reset: every flop they feed is held in
    // reset anyway. Only the visible acks are forced low.
    assign vid_ack_o     = w_vid_gnt   & reset_n;
    assign regs_rd_ack_o = w_rr_gnt[0] & reset_n;
    assign regs_wr_ack_o = w_rr_gnt[1] & reset_n;
    assign blit_ack_o    = w_rr_gnt[2] & reset_n;

    always_comb begin
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_rr_gnt[0])      w_rr_ptr_nxt = RR_WR;
        else if (w_rr_gnt[1]) w_rr_ptr_nxt = RR_BLIT;
        else if (w_rr_gnt[2]) w_rr_ptr_nxt = RR_RD;
    end

    // Winner mux for the VRAM port. Reads that carry no data keep the old
    // write-data value so vram_data_o only changes when it matters.
    always_comb begin
        w_we     = 1'b0;
        w_addr   = r_vram_addr;
        w_data   = r_vram_data;
        w_rd_tag = 3'b000;
        if (w_vid_gnt) begin
            w_addr      = vid_addr_i;
            w_rd_tag[0] = 1'b1;
        end else if (w_rr_gnt[0]) begin
            w_addr      = regs_rd_addr_i;
            w_rd_tag[1] = 1'b1;
        end else if (w_rr_gnt[1]) begin
            w_we   = 1'b1;
            w_addr = regs_wr_addr_i;
            w_data = regs_wr_data_i;
        end else if (w_rr_gnt[2]) begin
            w_we        = blit_we_i;
            w_addr      = blit_addr_i;
            w_data      = blit_data_i;
            w_rd_tag[2] = ~blit_we_i;
        end
    end

    assign w_xfer = w_vid_gnt | (|w_rr_gnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= RR_RD;
            for (int i = 0; i < 3; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            r_rr_ptr <= w_rr_ptr_nxt;
            for (int i = 0; i < 3; i++) begin
                if (!w_rr_req[i] || w_rr_gnt[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != WAIT_MAX) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vram_sel  <= 1'b0;
            r_vram_wr   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
        end else begin
            r_vram_sel <= w_xfer;
            r_vram_wr  <= w_xfer & w_we;
            if (w_xfer) begin
                r_vram_addr <= w_addr;
                r_vram_data <= w_data;
            end
        end
    end

    // Owner tags: tag1 = read issued to the port, tag2 = VRAM is sampling it,
    // r_valid = data captured from vram_data_i and presented to the owner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag1    <= 3'b000;
            r_tag2    <= 3'b000;
            r_valid   <= 3'b000;
            r_rd_data <= '0;
        end else begin
            r_tag1  <= w_rd_tag;
            r_tag2  <= r_tag1;
            r_valid <= r_tag2;
            if (|r_tag2) begin
                r_rd_data <= vram_data_i;
            end
        end
    end

    assign vram_sel_o      = r_vram_sel;
    assign vram_wr_o       = r_vram_wr;
    assign vram_addr_o     = r_vram_addr;
    assign vram_data_o     = r_vram_data;
    assign rd_data_o       = r_rd_data;
    assign vid_rd_valid_o  = r_valid[0];
    assign regs_rd_valid_o = r_valid[1];
    assign blit_rd_valid_o = r_valid[2];

endmodule
